// File: rtl/datapath_module_pkg.sv
// Shared constants, enums and helpers for the 16-bit single-cycle datapath.
// Field positions describe the instruction word as seen on mem_instr_out.
package datapath_module_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RM_MSB   = 7;
  localparam int RM_LSB   = 5;
  localparam int RN_MSB   = 4;
  localparam int RN_LSB   = 2;
  localparam int IMM5_MSB = 4;
  localparam int IMM8_MSB = 7;
  localparam int L8_MSB   = 7;
  localparam int L11_MSB  = 10;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_ADC,
    ALU_SUB,
    ALU_SBB
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_NONE,
    WB_MEM,
    WB_ALU,
    WB_RM,
    WB_PC,
    WB_LHI,
    WB_LLI
  } wb_sel_e;

  function automatic logic [DATA_W-1:0] sext11(input logic [L11_MSB:0] v);
    return {{(DATA_W-L11_MSB-1){v[L11_MSB]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [L8_MSB:0] v);
    return {{(DATA_W-L8_MSB-1){v[L8_MSB]}}, v};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Add/subtract core: subtraction is A + ~B + carry-in, so one adder serves all four ops.
// Produces the result plus carry, signed overflow, zero and negative flags.
module datapath_alu
  import datapath_module_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  input  logic              c_i,
  output logic [DATA_W-1:0] result_o,
  output logic              c_o,
  output logic              v_o,
  output logic              z_o,
  output logic              n_o
);

  logic [DATA_W-1:0] b_eff;
  logic              cin;
  logic [DATA_W:0]   sum;

  always_comb begin
    b_eff = b_i;
    cin   = 1'b0;
    case (op_i)
      ALU_ADC: cin = c_i;
      ALU_SUB: begin
        b_eff = ~b_i;
        cin   = 1'b1;
      end
      ALU_SBB: begin
        b_eff = ~b_i;
        cin   = c_i;
      end
      default: cin = 1'b0;
    endcase
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    result_o = sum[DATA_W-1:0];
    c_o      = sum[DATA_W];
    // Overflow judged on the operands actually fed to the adder (B already inverted).
    v_o      = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    z_o      = (sum[DATA_W-1:0] == '0);
    n_o      = sum[DATA_W-1];
  end

endmodule

// File: rtl/datapath_module.sv
// 16-bit single-cycle RISC datapath: PC, IMEM, 8x16 register file, ALU, DMEM, next-PC.
// Define DATAPATH_DBG_EN to expose dbg_pc and dbg_c.
module datapath_module
  import datapath_module_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flag_HLT,
  input  logic              test_normal,
  input  logic              ext_instr_we,
  input  logic [DATA_W-1:0] ext_instr_addr,
  input  logic [DATA_W-1:0] ext_instr_data,
  input  logic              ext_data_write_en,
  input  logic [DATA_W-1:0] ext_data_addr,
  input  logic [DATA_W-1:0] ext_data_data,
  output logic [DATA_W-1:0] mem_instr_out,
  input  logic              Src_Read_B,
  input  logic              Src_ALU_B,
  input  logic              ADC,
  input  logic              SUB,
  input  logic              SBB,
  input  logic              JMP,
  input  logic              BRANCH,
  input  logic              flag_label_PC,
  input  logic              flag_Rm_PC,
  input  logic              flag_Rd_PC,
  input  logic              data_write_en,
  input  logic              RF_write_en,
  input  logic              flag_mem_RF,
  input  logic              flag_ALU_RF,
  input  logic              flag_Rm_RF,
  input  logic              flag_PC_RF,
  input  logic              LHI,
  input  logic              LLI,
  output logic              Pre_C,
  output logic              Pre_V,
  output logic              Pre_Z,
  output logic              Pre_N
`ifdef DATAPATH_DBG_EN
  ,
  output logic [DATA_W-1:0] dbg_pc,
  output logic              dbg_c
`endif
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [DATA_W-1:0] imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic [DATA_W-1:0] rf_q   [NUM_REGS];
  logic [DATA_W-1:0] rf_d   [NUM_REGS];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              c_q, c_d;

  logic [DATA_W-1:0] instr;
  logic [REG_AW-1:0] rd, rm, rn;
  logic [DATA_W-1:0] port_a, port_b, rd_val, alu_b, alu_res;
  logic [DATA_W-1:0] dmem_rd_data, wb_data;
  logic [DATA_W-1:0] pc_plus1, label_off, pc_target;
  logic [IAW-1:0]    imem_rd_idx, imem_wr_idx;
  logic [DAW-1:0]    dmem_rd_idx, dmem_wr_idx;
  logic [DATA_W-1:0] dmem_wr_data;
  logic              dmem_we, imem_we, rf_we;
  logic              alu_c, alu_v, alu_z, alu_n;
  alu_op_e           alu_op;
  wb_sel_e           wb_sel;
  logic              unused_instr_hi;

  // Instruction fetch: in test mode the external address steers the read port.
  assign imem_rd_idx   = IAW'({16'd0, (test_normal ? ext_instr_addr : pc_q)} % IMEM_DEPTH);
  assign mem_instr_out = imem_q[imem_rd_idx];
  assign instr         = mem_instr_out;

  assign rd              = instr[RD_MSB:RD_LSB];
  assign rm              = instr[RM_MSB:RM_LSB];
  assign rn              = instr[RN_MSB:RN_LSB];
  assign unused_instr_hi = ^instr[DATA_W-1:L11_MSB+1];

  assign port_a = rf_q[rm];
  assign rd_val = rf_q[rd];
  assign port_b = Src_Read_B ? rd_val : rf_q[rn];
  assign alu_b  = Src_ALU_B ? {{(DATA_W-IMM5_MSB-1){1'b0}}, instr[IMM5_MSB:0]} : port_b;

  always_comb begin
    alu_op = ALU_ADD;
    if (SBB)      alu_op = ALU_SBB;
    else if (SUB) alu_op = ALU_SUB;
    else if (ADC) alu_op = ALU_ADC;
  end

  datapath_alu u_alu (
    .a_i      (port_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .c_i      (c_q),
    .result_o (alu_res),
    .c_o      (alu_c),
    .v_o      (alu_v),
    .z_o      (alu_z),
    .n_o      (alu_n)
  );

  assign Pre_C = alu_c;
  assign Pre_V = alu_v;
  assign Pre_Z = alu_z;
  assign Pre_N = alu_n;

  assign dmem_rd_idx  = DAW'({16'd0, alu_res} % DMEM_DEPTH);
  assign dmem_rd_data = dmem_q[dmem_rd_idx];

  // In test mode only the external port may write DMEM; the core's write is ignored.
  assign dmem_we      = test_normal ? ext_data_write_en : data_write_en;
  assign dmem_wr_idx  = DAW'({16'd0, (test_normal ? ext_data_addr : alu_res)} % DMEM_DEPTH);
  assign dmem_wr_data = test_normal ? ext_data_data : port_b;
  assign imem_we      = test_normal & ext_instr_we;
  assign imem_wr_idx  = IAW'({16'd0, ext_instr_addr} % IMEM_DEPTH);

  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_wr_idx] <= ext_instr_data;
    if (dmem_we) dmem_q[dmem_wr_idx] <= dmem_wr_data;
  end

  always_comb begin
    wb_sel = WB_NONE;
    if (flag_mem_RF)      wb_sel = WB_MEM;
    else if (flag_ALU_RF) wb_sel = WB_ALU;
    else if (flag_Rm_RF)  wb_sel = WB_RM;
    else if (flag_PC_RF)  wb_sel = WB_PC;
    else if (LHI)         wb_sel = WB_LHI;
    else if (LLI)         wb_sel = WB_LLI;
  end

  always_comb begin
    wb_data = '0;
    case (wb_sel)
      WB_MEM:  wb_data = dmem_rd_data;
      WB_ALU:  wb_data = alu_res;
      WB_RM:   wb_data = port_a;
      WB_PC:   wb_data = pc_plus1;
      WB_LHI:  wb_data = {instr[IMM8_MSB:0], rd_val[7:0]};
      WB_LLI:  wb_data = {rd_val[15:8], instr[IMM8_MSB:0]};
      default: wb_data = '0;
    endcase
  end

  assign rf_we = RF_write_en & ~test_normal & (wb_sel != WB_NONE);

  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[rd] = wb_data;
  end

  always_comb begin
    c_d = c_q;
    if (RF_write_en && flag_ALU_RF && !test_normal) c_d = alu_c;
  end

  always_comb begin
    pc_plus1  = pc_q + 16'd1;
    label_off = JMP ? sext11(instr[L11_MSB:0]) : sext8(instr[L8_MSB:0]);
    pc_target = pc_plus1;
    if (flag_label_PC)   pc_target = pc_plus1 + label_off;
    else if (flag_Rm_PC) pc_target = port_a;
    else if (flag_Rd_PC) pc_target = rd_val;
    pc_d = pc_q;
    if (!test_normal && !flag_HLT) pc_d = (JMP || BRANCH) ? pc_target : pc_plus1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q <= '0;
      c_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      c_q  <= c_d;
      rf_q <= rf_d;
    end
  end

`ifdef DATAPATH_DBG_EN
  assign dbg_pc = pc_q;
  assign dbg_c  = c_q;
`endif

endmodule

// File: tb/tb_datapath_module.sv
// Self-checking bench for datapath_module: directed test-plan steps plus random
// instructions checked against an arithmetic reference model of the architecture.
module tb_datapath_module;

  logic        clk = 1'b0;
  logic        clr;
  logic        flag_HLT, test_normal;
  logic        ext_instr_we, ext_data_write_en;
  logic [15:0] ext_instr_addr, ext_instr_data, ext_data_addr, ext_data_data;
  logic [15:0] mem_instr_out;
  logic        Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH;
  logic        flag_label_PC, flag_Rm_PC, flag_Rd_PC, data_write_en, RF_write_en;
  logic        flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI;
  logic        Pre_C, Pre_V, Pre_Z, Pre_N;
`ifdef DATAPATH_DBG_EN
  logic [15:0] dbg_pc;
  logic        dbg_c;
`endif

  datapath_module dut (
    .clk(clk), .clr(clr), .flag_HLT(flag_HLT), .test_normal(test_normal),
    .ext_instr_we(ext_instr_we), .ext_instr_addr(ext_instr_addr), .ext_instr_data(ext_instr_data),
    .ext_data_write_en(ext_data_write_en), .ext_data_addr(ext_data_addr), .ext_data_data(ext_data_data),
    .mem_instr_out(mem_instr_out), .Src_Read_B(Src_Read_B), .Src_ALU_B(Src_ALU_B),
    .ADC(ADC), .SUB(SUB), .SBB(SBB), .JMP(JMP), .BRANCH(BRANCH),
    .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC), .flag_Rd_PC(flag_Rd_PC),
    .data_write_en(data_write_en), .RF_write_en(RF_write_en),
    .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
    .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI),
    .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z), .Pre_N(Pre_N)
`ifdef DATAPATH_DBG_EN
    , .dbg_pc(dbg_pc), .dbg_c(dbg_c)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Architectural reference state
  logic [15:0] m_reg [8];
  logic [15:0] m_dmem [256];
  logic [15:0] m_pc;
  logic        m_c;
  logic [3:0]  obs_flags;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_ctrl();
    Src_Read_B = 0; Src_ALU_B = 0; ADC = 0; SUB = 0; SBB = 0; JMP = 0; BRANCH = 0;
    flag_label_PC = 0; flag_Rm_PC = 0; flag_Rd_PC = 0; data_write_en = 0; RF_write_en = 0;
    flag_mem_RF = 0; flag_ALU_RF = 0; flag_Rm_RF = 0; flag_PC_RF = 0; LHI = 0; LLI = 0;
  endtask

  task automatic model_reset();
    m_pc = 16'h0;
    m_c  = 1'b0;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
  endtask

  // ALU reference in plain integer arithmetic
  task automatic ref_alu(input logic [15:0] ins, output logic [15:0] res,
                         output logic cf, output logic vf);
    logic [15:0] a, b;
    int cin, s, ss;
    a = m_reg[ins[7:5]];
    b = Src_Read_B ? m_reg[ins[10:8]] : m_reg[ins[4:2]];
    if (Src_ALU_B) b = {11'd0, ins[4:0]};
    cin = 0;
    if (SBB)      begin b = ~b; cin = int'(m_c); end
    else if (SUB) begin b = ~b; cin = 1; end
    else if (ADC) cin = int'(m_c);
    s   = int'(a) + int'(b) + cin;
    res = s[15:0];
    cf  = s[16];
    ss  = int'($signed(a)) + int'($signed(b)) + cin;
    vf  = (ss > 32767) || (ss < -32768);
  endtask

  // Load ins at IMEM[PC] in test mode, then execute it for one cycle in normal mode.
  task automatic exec(input logic [15:0] ins);
    logic [15:0] res, wd, npc, a_v, b_v, rd_v;
    logic cf, vf, we;
    int rd, off, didx;
    rd = int'(ins[10:8]);
    test_normal = 1; ext_instr_we = 1; ext_instr_addr = m_pc; ext_instr_data = ins;
    @(posedge clk); #1;
    ext_instr_we = 0;
    chk("hold_pc", dut.pc_q, m_pc);
    chk("hold_rd", dut.rf_q[rd], m_reg[rd]);
    chk("hold_c", {15'd0, dut.c_q}, {15'd0, m_c});
    test_normal = 0; #1;
    chk("instr", mem_instr_out, ins);
    ref_alu(ins, res, cf, vf);
    obs_flags = {Pre_C, Pre_V, Pre_Z, Pre_N};
    chk("flags", {12'd0, obs_flags}, {12'd0, cf, vf, (res == 16'h0), res[15]});

    a_v  = m_reg[ins[7:5]];
    rd_v = m_reg[rd];
    b_v  = Src_Read_B ? rd_v : m_reg[ins[4:2]];
    didx = int'(res) % 256;
    we = RF_write_en;
    wd = 16'h0;
    if (flag_mem_RF)      wd = m_dmem[didx];
    else if (flag_ALU_RF) wd = res;
    else if (flag_Rm_RF)  wd = a_v;
    else if (flag_PC_RF)  wd = m_pc + 16'd1;
    else if (LHI)         wd = {ins[7:0], rd_v[7:0]};
    else if (LLI)         wd = {rd_v[15:8], ins[7:0]};
    else                  we = 0;
    npc = m_pc;
    if (!flag_HLT) begin
      npc = m_pc + 16'd1;
      if (JMP || BRANCH) begin
        if (flag_label_PC) begin
          if (JMP) off = (int'(ins[10:0]) >= 1024) ? int'(ins[10:0]) - 2048 : int'(ins[10:0]);
          else     off = (int'(ins[7:0]) >= 128) ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
          npc = 16'(int'(m_pc) + 1 + off);
        end
        else if (flag_Rm_PC) npc = a_v;
        else if (flag_Rd_PC) npc = rd_v;
      end
    end

    @(posedge clk); #1;
    if (we) m_reg[rd] = wd;
    if (RF_write_en && flag_ALU_RF) m_c = cf;
    if (data_write_en) m_dmem[didx] = b_v;
    m_pc = npc;
    clear_ctrl();
    chk("pc", dut.pc_q, m_pc);
    chk("c", {15'd0, dut.c_q}, {15'd0, m_c});
    for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), dut.rf_q[i], m_reg[i]);
  endtask

  initial begin
    logic [15:0] ins;
    clear_ctrl();
    clr = 1; flag_HLT = 1; test_normal = 1;
    ext_instr_we = 0; ext_data_write_en = 0;
    ext_instr_addr = 0; ext_instr_data = 0; ext_data_addr = 0; ext_data_data = 0;
    model_reset();
    #12;
    chk("rst_pc", dut.pc_q, 16'h0);
    chk("rst_c", {15'd0, dut.c_q}, 16'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), dut.rf_q[i], 16'h0);
    @(negedge clk); clr = 0;

    // Test-mode load: fill DMEM so every later load reads a known value.
    for (int i = 1; i < 256; i++) begin
      ext_data_write_en = 1; ext_data_addr = 16'(i); ext_data_data = 16'($urandom);
      m_dmem[i] = ext_data_data;
      @(posedge clk); #1;
    end
    ext_instr_we = 1; ext_instr_addr = 16'h0; ext_instr_data = 16'h0001;
    ext_data_write_en = 1; ext_data_addr = 16'h0; ext_data_data = 16'h0003;
    m_dmem[0] = 16'h0003;
    @(posedge clk); #1;
    ext_instr_we = 0; ext_data_write_en = 0;
    #1;
    chk("tm_imem", mem_instr_out, 16'h0001);
    chk("tm_pc", dut.pc_q, 16'h0);

    // Load from memory into R2
    Src_ALU_B = 1; flag_mem_RF = 1; RF_write_en = 1;
    exec(16'h0200);
    chk("ld_r2", dut.rf_q[2], 16'h0003);
    chk("ld_pc", dut.pc_q, 16'h0);

    LLI = 1; RF_write_en = 1; exec(16'h0134);
    LHI = 1; RF_write_en = 1; exec(16'h0112);
    chk("lhi_r1", dut.rf_q[1], 16'h1234);

    // R3 = 0x7FFF, then R4 = R3 + 1
    LLI = 1; RF_write_en = 1; exec(16'h03FF);
    LHI = 1; RF_write_en = 1; exec(16'h037F);
    Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1; exec(16'h0461);
    chk("add_cvzn", {12'd0, obs_flags}, 16'h0005);
    chk("add_r4", dut.rf_q[4], 16'h8000);

    // R5 = 5, R6 = R5 - 5
    LLI = 1; RF_write_en = 1; exec(16'h0505);
    SUB = 1; Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1; exec(16'h06A5);
    chk("sub_cvzn", {12'd0, obs_flags}, 16'h000A);
    chk("sub_c", {15'd0, dut.c_q}, 16'h0001);

    // R7 = 1, R0 = R7 + 1 + C
    LLI = 1; RF_write_en = 1; exec(16'h0701);
    ADC = 1; Src_ALU_B = 1; flag_ALU_RF = 1; RF_write_en = 1; exec(16'h00E1);
    chk("adc_r0", dut.rf_q[0], 16'h0003);

    // PC sequencing and redirects
    flag_HLT = 0;
    exec(16'h0000); chk("pc_inc1", dut.pc_q, 16'h0001);
    exec(16'h0000); chk("pc_inc2", dut.pc_q, 16'h0002);
    JMP = 1; flag_label_PC = 1; exec(16'h07FE);
    chk("jmp_label", dut.pc_q, 16'h0001);
    flag_HLT = 1;
    LHI = 1; RF_write_en = 1; exec(16'h0300);
    LLI = 1; RF_write_en = 1; exec(16'h0340);
    flag_HLT = 0;
    JMP = 1; flag_Rm_PC = 1; exec(16'h0060);
    chk("jmp_rm", dut.pc_q, 16'h0040);

    // Random instructions and control mixes
    for (int it = 0; it < 80; it++) begin
      int w;
      clear_ctrl();
      flag_HLT      = ($urandom_range(3) != 0);
      Src_Read_B    = 1'($urandom);
      Src_ALU_B     = 1'($urandom);
      ADC           = ($urandom_range(3) == 0);
      SUB           = ($urandom_range(3) == 0);
      SBB           = ($urandom_range(3) == 0);
      RF_write_en   = ($urandom_range(3) != 0);
      data_write_en = ($urandom_range(3) == 0);
      JMP           = ($urandom_range(3) == 0);
      BRANCH        = ($urandom_range(3) == 0);
      flag_label_PC = 1'($urandom);
      flag_Rm_PC    = 1'($urandom);
      flag_Rd_PC    = 1'($urandom);
      w = int'($urandom_range(6));
      flag_mem_RF = (w == 1); flag_ALU_RF = (w == 2); flag_Rm_RF = (w == 3);
      flag_PC_RF  = (w == 4); LHI = (w == 5); LLI = (w == 6);
      if ($urandom_range(3) == 0) begin
        LLI = 1; flag_PC_RF = flag_PC_RF | 1'($urandom);
      end
      ins = 16'($urandom);
      exec(ins);
    end

    // Asynchronous reset mid-run, away from any clock edge
    @(negedge clk);
    clr = 1; #1;
    model_reset();
    chk("arst_pc", dut.pc_q, 16'h0);
    chk("arst_c", {15'd0, dut.c_q}, 16'h0);
    for (int i = 0; i < 8; i++) chk($sformatf("arst_r%0d", i), dut.rf_q[i], 16'h0);
    #2; clr = 0;
    flag_HLT = 0;
    exec(16'h0000);
    chk("post_rst_pc", dut.pc_q, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/datapath_module.md
Name: datapath_module

Overview:
- 16-bit single-cycle RISC datapath: PC, instruction memory, 8x16 register file, add/sub ALU with carry flag, data memory, and next-PC logic.
- All mux selects and write enables come from an external controller, which decodes mem_instr_out and consumes the Pre_* flags.
- Test mode (test_normal=1) lets an external bench load both memories while the core is frozen.

Parameters:
- IMEM_DEPTH, 256, instruction memory words; address = PC/ext_instr_addr modulo depth.
- DMEM_DEPTH, 256, data memory words; address modulo depth.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- flag_HLT  in  1  1 = PC holds.
- test_normal  in  1  1 = test/load mode, 0 = normal execution.
- ext_instr_we  in  1  test-mode instruction memory write enable.
- ext_instr_addr  in  16  test-mode instruction memory address.
- ext_instr_data  in  16  test-mode instruction memory write data.
- ext_data_write_en  in  1  test-mode data memory write enable.
- ext_data_addr  in  16  test-mode data memory address.
- ext_data_data  in  16  test-mode data memory write data.
- mem_instr_out  out  16  instruction read: IMEM[PC] in normal mode, IMEM[ext_instr_addr] in test mode.
- Src_Read_B  in  1  read port B address: 1 = Rd, 0 = Rn.
- Src_ALU_B  in  1  ALU B operand: 1 = zero-extended imm5, 0 = port B.
- ADC, SUB, SBB  in  1 each  ALU operation select; none asserted = ADD.
- JMP, BRANCH  in  1 each  PC redirect enables.
- flag_label_PC, flag_Rm_PC, flag_Rd_PC  in  1 each  redirect target select.
- data_write_en  in  1  normal-mode data memory write.
- RF_write_en  in  1  register file write.
- flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI  in  1 each  RF write-data select (one-hot).
- Pre_C, Pre_V, Pre_Z, Pre_N  out  1 each  combinational flags of the current ALU result.

Behaviour:
- Instruction fields: Rd=[10:8], Rm=[7:5], Rn=[4:2], imm5=[4:0], imm8=[7:0], label8=[7:0], label11=[10:0].
- Reset (clr=1, async): PC=0, all 8 registers=0, carry register C=0. Memories are not cleared.
- RF reads are asynchronous. Port A = R[Rm]. Port B = R[Rd] or R[Rn], selected by Src_Read_B.
- ALU A = port A; ALU B per Src_ALU_B.
- ALU operations:
  - ADD: A+B.
  - ADC: A+B+C.
  - SUB: A+~B+1.
  - SBB: A+~B+C.
  - Priority if several asserted: SBB > SUB > ADC.
- Flags:
  - Pre_C = carry out of bit 15.
  - Pre_V = signed overflow of the effective addition.
  - Pre_Z = (result==0).
  - Pre_N = result[15].
- C <= Pre_C on posedge when RF_write_en & flag_ALU_RF & !test_normal.
- RF write on posedge when RF_write_en & !test_normal, to register Rd. Data select priority:
  - flag_mem_RF: DMEM read data.
  - flag_ALU_RF: ALU result.
  - flag_Rm_RF: R[Rm].
  - flag_PC_RF: PC+1.
  - LHI: {imm8, R[Rd][7:0]}.
  - LLI: {R[Rd][15:8], imm8}.
  - None asserted: write suppressed.
- DMEM:
  - Read is asynchronous at the ALU result address.
  - Normal-mode write on posedge when data_write_en: data = port B, address = ALU result.
  - Test mode: writes only via ext_data_write_en at ext_data_addr; data_write_en is ignored.
- IMEM:
  - Read is asynchronous.
  - Test-mode write on posedge when ext_instr_we.
  - Never written in normal mode.
- PC:
  - Updates on posedge only when !test_normal & !flag_HLT; otherwise holds.
  - next_PC = PC+1 by default.
  - If JMP or BRANCH, the target is selected with priority flag_label_PC > flag_Rm_PC > flag_Rd_PC:
    - label: PC+1+sext(label11) for JMP, PC+1+sext(label8) for BRANCH.
    - Rm: R[Rm]; Rd: R[Rd].
    - No select asserted: PC+1.
  - The controller asserts BRANCH only when the condition holds.
- All arithmetic is 16-bit modulo 2^16. PC wraps FFFF->0000; memory addresses wrap modulo depth.
- Writing R[Rd] while reading it: the read returns the old value in the same cycle.

Optional Feature:
- DATAPATH_DBG_EN defined: adds outputs dbg_pc[15:0] (current PC) and dbg_c (carry register).
- Not defined: these ports are absent; no other behaviour changes.

Decomposition:
- Shared package holds:
  - field bit-position constants (RD_MSB etc.);
  - DATA_W=16;
  - NUM_REGS=8.
- One natural sub-module: datapath_alu (add/sub core with carry-in and C/V/Z/N generation).
- Register file, memories and PC stay inline.

Test Plan:
- Test-mode load:
  - Write IMEM[0]=0x0001 and DMEM[0]=0x0003 with test_normal=1.
  - Expect mem_instr_out=0x0001 at ext_instr_addr=0 and PC stays 0.
- Load from memory:
  - test_normal=0, HLT=1, instruction with Rd=2, Rm=0, imm5=0, Src_ALU_B=1, flag_mem_RF=1, RF_write_en=1.
  - Expect R2=0x0003 and PC still 0.
- LLI/LHI:
  - LLI imm8=0x34 to R1, then LHI imm8=0x12 to R1.
  - Expect R1=0x1234.
- Arithmetic:
  - ADD 0x7FFF+0x0001 -> result 0x8000, V=1, N=1, C=0, Z=0.
  - SUB 5-5 -> Z=1, C=1.
  - Then ADC 1+1 -> 3.
- PC:
  - HLT=0, no redirect: PC 0->1->2.
  - JMP with flag_label_PC and label11=0x7FE (-2) at PC=2: next PC=1.
  - flag_Rm_PC with R[Rm]=0x0040: PC=0x0040.
- Reset: assert clr mid-run; expect PC=0 and all registers=0 immediately, with no clock edge needed.
